load_hash_vector: RTL and testbench
===================================

// Module: load_hash_vector
// PURPOSE
//  Reads HASH_LENGTH 32-bit words from a word-addressed synchronous memory and assembles them into one 256-bit vector.
//  Memory word i lands at hash_vector[i*32 +: 32], so a stored hash round-trips unchanged.
//  Sits between H/message memory and the SHA-256 core; presents the vector with a valid/ready handshake.
// PARAMETERS
//  HASH_LENGTH  8   words per vector; vector width = HASH_LENGTH*32
//  ADDR_WIDTH   16  memory address width
//  RD_LATENCY   1   cycles from mem_read high to mem_data valid; legal range 1..4
// PORTS
//  clock          in   1               clock
//  reset          in   1               synchronous, active-high reset
//  start          in   1               begin a load; sampled only in IDLE
//  base_address   in   ADDR_WIDTH      address of word 0; sampled with start
//  mem_read       out  1               read strobe, one word per cycle
//  mem_address    out  ADDR_WIDTH      read address
//  mem_data       in   32              read data, RD_LATENCY cycles after its strobe
//  hash_vector    out  HASH_LENGTH*32  assembled vector
//  vector_valid   out  1               hash_vector complete and stable
//  vector_ready   in   1               consumer accepts the vector
//  busy           out  1               high in any state other than IDLE
// BEHAVIOUR
//  Reset values: mem_read=0, mem_address=0, hash_vector=0, vector_valid=0, busy=0, state=IDLE, tag pipe empty.
//  States:
//   IDLE:  start=1 -> ISSUE; latch base_address; index=0.
//   ISSUE: mem_read=1; mem_address=base+index, wrapping modulo 2^ADDR_WIDTH.
//          Push tag {1,index} into the RD_LATENCY-deep tag pipe; index++.
//          After index HASH_LENGTH-1 is issued -> DRAIN.
//   DRAIN: mem_read=0; wait until the last tag exits the pipe -> HOLD.
//   HOLD:  vector_valid=1, hash_vector held stable; vector_ready=1 -> IDLE; vector_valid=0 next cycle.
//  Capture: when a valid tag exits the pipe, the clock edge writes mem_data to hash_vector[tag*32 +: 32].
//  Timing, HASH_LENGTH=8, RD_LATENCY=1, start at cycle T:
//   - strobes in cycles T+1..T+8, addresses base..base+7
//   - last word captured at end of T+9
//   - vector_valid=1 from T+10
//  Load latency is HASH_LENGTH+RD_LATENCY+1 cycles from start to vector_valid.
//  start is ignored outside IDLE, including in HOLD when vector_ready is high in the same cycle.
//  vector_ready is ignored outside HOLD.
//  hash_vector is not cleared on start; each word is overwritten as it is captured.
//  mem_address keeps its last value when mem_read=0.
//  Reset mid-load: all outputs and the tag pipe return to reset values immediately.
//   In-flight read data arriving after reset is discarded.
//  base near top of address space: addresses wrap (e.g. base=0xFFFE -> 0xFFFE, 0xFFFF, 0x0000, ...).
// CONFIGURATION
//  HASH_LOAD_BYTESWAP_EN defined: each captured word is byte-reversed before storage (0x11223344 -> 0x44332211).
//   Covers big-endian message memory.
//  HASH_LOAD_BYTESWAP_EN undefined: words are stored exactly as read.
//  Timing is identical either way.
// STRUCTURE
//  sha256_pkg: WORD_WIDTH=32; HASH_WORDS=8; load_state_t enum {IDLE, ISSUE, DRAIN, HOLD};
//   byte_swap32 function.
//  Sub-module read_tag_pipe: RD_LATENCY-stage shift register of {valid, index};
//   synchronous clear on reset; reports out_valid, out_index and empty.
//  Top level holds the FSM, index/address counter and capture logic.
// TESTING
//  1. base=0x0010, mem[0x10+i]=0xA0000000+i, RD_LATENCY=1, start pulse
//     -> 8 strobes at 0x10..0x17; vector_valid at T+10;
//     hash_vector[31:0]=0xA0000000, [255:224]=0xA0000007.
//  2. vector_ready held low for 20 cycles after valid
//     -> vector_valid and hash_vector stable for the whole wait; mem_read=0; new start ignored.
//  3. base=0xFFFE -> addresses 0xFFFE, 0xFFFF, 0x0000..0x0005; words placed in index order.
//  4. RD_LATENCY=3 build -> vector_valid at T+12; no word shifted or duplicated.
//  5. reset asserted in cycle T+4 of a load -> next cycle all outputs 0, state IDLE;
//     late read data does not modify hash_vector; a fresh start then completes correctly.
//  6. HASH_LOAD_BYTESWAP_EN defined, mem word 0x11223344 at index 0
//     -> hash_vector[31:0]=0x44332211; without the macro -> 0x11223344.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared definitions for the hash load path.
//   WORD_WIDTH   - width of one memory / hash word
//   HASH_WORDS   - words in a SHA-256 state vector
//   load_state_t - states of the vector loader
//   byte_swap32  - reverses byte order of a 32-bit word
package sha256_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int HASH_WORDS = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    HOLD
  } load_state_t;

  function automatic logic [31:0] byte_swap32(input logic [31:0] word);
    return {word[7:0], word[15:8], word[23:16], word[31:24]};
  endfunction

endpackage

// File: rtl/read_tag_pipe.sv
// Delay line that follows each memory read strobe through the read latency,
// so the returning data word can be matched to the vector slot it belongs to.
// Ports:
//   clock, reset        - clock, synchronous active-high clear
//   in_valid, in_index  - tag entering with the read strobe
//   out_valid, out_index- tag leaving alongside the matching read data
//   empty               - no valid tag anywhere in the pipe
module read_tag_pipe #(
  parameter int DEPTH = 1,
  parameter int IDX_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_index,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_index,
  output logic             empty
);

  logic [DEPTH-1:0] valid_q;
  logic [IDX_W-1:0] index_q [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) index_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      index_q[0] <= in_index;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        index_q[i] <= index_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_index = index_q[DEPTH-1];
  assign empty     = (valid_q == '0);

endmodule

// File: rtl/load_hash_vector.sv
// Reads HASH_LENGTH consecutive words from a synchronous, word-addressed
// memory and assembles them into one vector (word i at bits i*32 +: 32),
// then offers the vector to the consumer with a valid/ready handshake.
// Optional macro: HASH_LOAD_BYTESWAP_EN - byte-reverse each word on capture.
// Parameters: HASH_LENGTH (words), ADDR_WIDTH, RD_LATENCY (1..4 cycles).
// Ports:
//   clock, reset               - clock, synchronous active-high reset
//   start, base_address        - begin a load at base_address (IDLE only)
//   mem_read, mem_address      - read strobe and address, one word per cycle
//   mem_data                   - read data, RD_LATENCY cycles after its strobe
//   hash_vector, vector_valid  - assembled vector and its valid flag
//   vector_ready               - consumer accepts the vector
//   busy                       - a load is in progress or being held
module load_hash_vector
  import sha256_pkg::*;
#(
  parameter int HASH_LENGTH = HASH_WORDS,
  parameter int ADDR_WIDTH  = 16,
  parameter int RD_LATENCY  = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       base_address,
  output logic                        mem_read,
  output logic [ADDR_WIDTH-1:0]       mem_address,
  input  logic [WORD_WIDTH-1:0]       mem_data,
  output logic [HASH_LENGTH*WORD_WIDTH-1:0] hash_vector,
  output logic                        vector_valid,
  input  logic                        vector_ready,
  output logic                        busy
);

  localparam int IDX_W = (HASH_LENGTH > 1) ? $clog2(HASH_LENGTH) : 1;
  localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(HASH_LENGTH - 1);

  load_state_t           state;
  logic [IDX_W-1:0]      issue_index;
  logic                  tag_valid;
  logic [IDX_W-1:0]      tag_index;
  logic                  pipe_empty;
  logic [WORD_WIDTH-1:0] capture_word;

`ifdef HASH_LOAD_BYTESWAP_EN
  assign capture_word = byte_swap32(mem_data);
`else
  assign capture_word = mem_data;
`endif

  // The tag enters together with the strobe, so it leaves exactly when the
  // memory presents that strobe's data.
  read_tag_pipe #(
    .DEPTH(RD_LATENCY),
    .IDX_W(IDX_W)
  ) u_tag_pipe (
    .clock    (clock),
    .reset    (reset),
    .in_valid (mem_read),
    .in_index (issue_index),
    .out_valid(tag_valid),
    .out_index(tag_index),
    .empty    (pipe_empty)
  );

  // The pipe is always empty in IDLE; including it keeps busy high for any
  // read still in flight.
  assign busy = (state != IDLE) || !pipe_empty;

  // mem_read/mem_address describe the word being strobed this cycle and
  // issue_index names its slot; the address simply increments and wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      mem_read     <= 1'b0;
      mem_address  <= '0;
      issue_index  <= '0;
      vector_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= ISSUE;
            mem_read    <= 1'b1;
            mem_address <= base_address;
            issue_index <= '0;
          end
        end
        ISSUE: begin
          if (issue_index == LAST_INDEX) begin
            mem_read <= 1'b0;
            state    <= DRAIN;
          end else begin
            issue_index <= issue_index + IDX_W'(1);
            mem_address <= mem_address + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          // The last word is written on this same edge, so valid rises with
          // a complete vector.
          if (tag_valid && tag_index == LAST_INDEX) begin
            state        <= HOLD;
            vector_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (vector_ready) begin
            state        <= IDLE;
            vector_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture is driven only by the tag pipe, so data returning after a reset
  // (pipe cleared) is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      hash_vector <= '0;
    end else begin
      for (int w = 0; w < HASH_LENGTH; w++) begin
        if (tag_valid && tag_index == IDX_W'(w))
          hash_vector[w*WORD_WIDTH +: WORD_WIDTH] <= capture_word;
      end
    end
  end

endmodule

// File: tb/tb_load_hash_vector.sv
// Testbench for load_hash_vector: two instances (read latency 1 and 3) share
// one behavioural memory and one set of control inputs. Expected vectors,
// addresses and latencies come from a reference model of the load rules.
// Honours HASH_LOAD_BYTESWAP_EN when computing expected words.
module tb_load_hash_vector;

  localparam int HL = 8;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  base_address = '0;
  logic         vector_ready = 1'b0;

  logic         mem_read_a, mem_read_b;
  logic [15:0]  mem_address_a, mem_address_b;
  logic [31:0]  mem_data_a, mem_data_b;
  logic [255:0] hash_vector_a, hash_vector_b;
  logic         vector_valid_a, vector_valid_b;
  logic         busy_a, busy_b;

  logic [31:0]  mem [0:65535];
  logic [31:0]  delay_a;
  logic [31:0]  delay_b [3];
  logic [15:0]  addr_q_a[$];
  logic [15:0]  addr_q_b[$];

  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  load_hash_vector #(.HASH_LENGTH(HL), .ADDR_WIDTH(16), .RD_LATENCY(LAT_A)) dut_a (
    .clock(clock), .reset(reset), .start(start), .base_address(base_address),
    .mem_read(mem_read_a), .mem_address(mem_address_a), .mem_data(mem_data_a),
    .hash_vector(hash_vector_a), .vector_valid(vector_valid_a),
    .vector_ready(vector_ready), .busy(busy_a));

  load_hash_vector #(.HASH_LENGTH(HL), .ADDR_WIDTH(16), .RD_LATENCY(LAT_B)) dut_b (
    .clock(clock), .reset(reset), .start(start), .base_address(base_address),
    .mem_read(mem_read_b), .mem_address(mem_address_b), .mem_data(mem_data_b),
    .hash_vector(hash_vector_b), .vector_valid(vector_valid_b),
    .vector_ready(vector_ready), .busy(busy_b));

  // Synchronous memory: data for an address appears LAT cycles later.
  always @(posedge clock) begin
    delay_a    <= mem[mem_address_a];
    delay_b[0] <= mem[mem_address_b];
    delay_b[1] <= delay_b[0];
    delay_b[2] <= delay_b[1];
  end
  assign mem_data_a = delay_a;
  assign mem_data_b = delay_b[2];

  // Record every strobed address.
  always @(negedge clock) begin
    if (mem_read_a) addr_q_a.push_back(mem_address_a);
    if (mem_read_b) addr_q_b.push_back(mem_address_b);
  end

  task automatic checkOutput(input string tag, input logic [255:0] actual,
                             input logic [255:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
  endtask

  function automatic logic [31:0] stored_word(input logic [31:0] w);
`ifdef HASH_LOAD_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [255:0] expected_vector(input logic [15:0] base);
    logic [255:0] v;
    logic [15:0]  a;
    v = '0;
    for (int i = 0; i < HL; i++) begin
      a = base + 16'(i);
      v[i*32 +: 32] = stored_word(mem[a]);
    end
    return v;
  endfunction

  task automatic fillRandom(input logic [15:0] base);
    logic [15:0] a;
    for (int i = 0; i < HL; i++) begin
      a = base + 16'(i);
      mem[a] = $urandom;
    end
  endtask

  // One full load on both instances: latency, addresses, vector contents,
  // stability while held, ignored start, and the handshake back to IDLE.
  task automatic applyStimulus(input logic [15:0] base, input int hold_cycles);
    int first_a, first_b, bad_a, bad_b, unstable;
    logic [255:0] exp_vec, held_a, held_b;
    logic [15:0] a;
    exp_vec = expected_vector(base);
    addr_q_a.delete();
    addr_q_b.delete();
    first_a = 0;
    first_b = 0;
    @(posedge clock); #1;
    start = 1'b1;
    base_address = base;
    @(posedge clock); #1;
    start = 1'b0;
    base_address = $urandom;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (vector_valid_a && first_a == 0) first_a = n;
      if (vector_valid_b && first_b == 0) first_b = n;
      if (first_a != 0 && first_b != 0) break;
    end
    checkOutput("latency_a", 256'(first_a), 256'(HL + LAT_A + 1));
    checkOutput("latency_b", 256'(first_b), 256'(HL + LAT_B + 1));
    checkOutput("vector_a", hash_vector_a, exp_vec);
    checkOutput("vector_b", hash_vector_b, exp_vec);
    checkOutput("strobes_a", 256'(addr_q_a.size()), 256'(HL));
    checkOutput("strobes_b", 256'(addr_q_b.size()), 256'(HL));
    bad_a = 0;
    bad_b = 0;
    for (int i = 0; i < HL; i++) begin
      a = base + 16'(i);
      if (i >= addr_q_a.size() || addr_q_a[i] !== a) bad_a++;
      if (i >= addr_q_b.size() || addr_q_b[i] !== a) bad_b++;
    end
    checkOutput("addr_seq_a", 256'(bad_a), 256'd0);
    checkOutput("addr_seq_b", 256'(bad_b), 256'd0);

    held_a = hash_vector_a;
    held_b = hash_vector_b;
    unstable = 0;
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clock);
      start = (i == hold_cycles / 2);
      if (hash_vector_a !== held_a || hash_vector_b !== held_b) unstable++;
      if (!vector_valid_a || !vector_valid_b || !busy_a || !busy_b) unstable++;
      if (mem_read_a || mem_read_b) unstable++;
    end
    start = 1'b0;
    checkOutput("hold_stable", 256'(unstable), 256'd0);

    // Release with start high in the same cycle: start must be ignored.
    @(negedge clock);
    vector_ready = 1'b1;
    start = 1'b1;
    @(negedge clock);
    vector_ready = 1'b0;
    start = 1'b0;
    checkOutput("release_valid_busy",
                256'({vector_valid_a, vector_valid_b, busy_a, busy_b}), 256'd0);
    @(negedge clock);
    checkOutput("idle_after_release",
                256'({busy_a, busy_b, mem_read_a, mem_read_b}), 256'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ctrl"},
                256'({mem_read_a, mem_read_b, vector_valid_a, vector_valid_b,
                      busy_a, busy_b, mem_address_a, mem_address_b}), 256'd0);
    checkOutput({tag, "_vec_a"}, hash_vector_a, 256'd0);
    checkOutput({tag, "_vec_b"}, hash_vector_b, 256'd0);
  endtask

  // Reset in cycle T+4 of a load, then watch for late data being captured.
  task automatic testMidLoadReset();
    int dirty;
    fillRandom(16'h0200);
    @(posedge clock); #1;
    start = 1'b1;
    base_address = 16'h0200;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checkResetOutputs("mid_reset");
    dirty = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (hash_vector_a !== '0 || hash_vector_b !== '0) dirty++;
      if (vector_valid_a || vector_valid_b || busy_a || busy_b) dirty++;
    end
    checkOutput("late_data_dropped", 256'(dirty), 256'd0);
  endtask

  initial begin
    logic [15:0] b;
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkResetOutputs("reset");
    @(posedge clock); #1;
    reset = 1'b0;

    // Fixed pattern at 0x0010 with a long hold.
    for (int i = 0; i < HL; i++) mem[16'h0010 + 16'(i)] = 32'hA000_0000 + 32'(i);
    applyStimulus(16'h0010, 20);
    checkOutput("pattern_word0", 256'(hash_vector_a[31:0]),
                256'(stored_word(32'hA000_0000)));
    checkOutput("pattern_word7", 256'(hash_vector_a[255:224]),
                256'(stored_word(32'hA000_0007)));

    // Address wrap at the top of memory.
    fillRandom(16'hFFFE);
    applyStimulus(16'hFFFE, 3);

    // Byte order of a known word at index 0.
    fillRandom(16'h0400);
    mem[16'h0400] = 32'h1122_3344;
    applyStimulus(16'h0400, 2);
`ifdef HASH_LOAD_BYTESWAP_EN
    checkOutput("byte_order", 256'(hash_vector_a[31:0]), 256'h4433_2211);
`else
    checkOutput("byte_order", 256'(hash_vector_a[31:0]), 256'h1122_3344);
`endif

    testMidLoadReset();
    fillRandom(16'h0200);
    applyStimulus(16'h0200, 2);

    for (int r = 0; r < 5; r++) begin
      b = 16'($urandom_range(0, 65535));
      fillRandom(b);
      applyStimulus(b, int'($urandom_range(0, 6)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
